// File: rtl/multi_phase_accumulator_if.sv
// Write/commit bus for multi_phase_accumulator: shadow-register writes plus the commit request.
// The master drives writes and commit; the slave (accumulator) returns wr_ready.
interface multi_phase_accumulator_if #(
    parameter int unsigned CHANNELS = 4,
    parameter int unsigned TUNE_W   = 16
);
    localparam int unsigned CH_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic              wr_en;
    logic [CH_W-1:0]   wr_ch;
    logic              wr_off;
    logic [TUNE_W-1:0] wr_data;
    logic              wr_ready;
    logic              commit;

    modport master (
        output wr_en,
        output wr_ch,
        output wr_off,
        output wr_data,
        output commit,
        input  wr_ready
    );

    modport slave (
        input  wr_en,
        input  wr_ch,
        input  wr_off,
        input  wr_data,
        input  commit,
        output wr_ready
    );
endinterface

// File: rtl/multi_phase_accumulator.sv
// Multi-channel NCO phase accumulator with shadowed tuning words and an atomic, ce-aligned commit.
// Define PHASE_OFFSET_EN to add per-channel phase offset registers (written with wr_off = 1).
module multi_phase_accumulator #(
    parameter int unsigned ACC_W    = 23,
    parameter int unsigned OUT_W    = 14,
    parameter int unsigned TUNE_W   = 16,
    parameter int unsigned CHANNELS = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ce,
    input  logic                      phase_sync,
    multi_phase_accumulator_if.slave  bus,
    output logic [CHANNELS*OUT_W-1:0] phase_out,
    output logic [CHANNELS-1:0]       wrap
);
    localparam int unsigned   CH_W      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam logic [CH_W:0] ChanLimit = (CH_W + 1)'(CHANNELS);

    localparam logic [0:0] StIdle    = 1'b0;
    localparam logic [0:0] StPending = 1'b1;

    logic [0:0]          r_state;
    logic [0:0]          w_state_d;
    logic                r_rdy;
    logic [ACC_W-1:0]    r_acc    [CHANNELS];
    logic [TUNE_W-1:0]   r_shadow [CHANNELS];
    logic [TUNE_W-1:0]   r_active [CHANNELS];
    logic [CHANNELS-1:0] r_wrap;

    logic [ACC_W:0]      w_sum    [CHANNELS];
    logic [OUT_W-1:0]    w_offset [CHANNELS];
    logic [CHANNELS-1:0] w_sel;
    logic                w_wr_acc;
    logic                w_wr_tune;
    logic                w_load;

    // r_rdy is low from reset until the first cycle after rst deasserts.
    assign bus.wr_ready = r_rdy & ~rst & (r_state == StIdle);
    assign w_wr_acc     = bus.wr_en & bus.wr_ready & ({1'b0, bus.wr_ch} < ChanLimit);
    assign w_wr_tune    = w_wr_acc & ~bus.wr_off;
    assign w_load       = (r_state == StPending) & ce;
    assign wrap         = r_wrap;

    always_comb begin
        w_state_d = r_state;
        case (r_state)
            StIdle:    if (bus.commit) w_state_d = StPending;
            StPending: if (ce) w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        assign w_sel[g] = (bus.wr_ch == CH_W'(g));
        assign w_sum[g] = {1'b0, r_acc[g]} + (ACC_W + 1)'(r_active[g]);
        assign phase_out[g*OUT_W +: OUT_W] = r_acc[g][ACC_W-1 -: OUT_W] + w_offset[g];
`ifdef PHASE_OFFSET_EN
        logic [OUT_W-1:0] r_offset;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_offset <= '0;
            end else if (w_wr_acc && bus.wr_off && w_sel[g]) begin
                r_offset <= OUT_W'(bus.wr_data);
            end
        end
        assign w_offset[g] = r_offset;
`else
        assign w_offset[g] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= StIdle;
            r_rdy   <= 1'b0;
            r_wrap  <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                r_acc[i]    <= '0;
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            r_state <= w_state_d;
            r_rdy   <= 1'b1;
            for (int i = 0; i < CHANNELS; i++) begin
                if (w_wr_tune && w_sel[i]) begin
                    r_shadow[i] <= bus.wr_data;
                end
                // The add in the load cycle still uses the old active word.
                if (w_load) begin
                    r_active[i] <= r_shadow[i];
                end
                if (phase_sync) begin
                    r_acc[i]  <= '0;
                    r_wrap[i] <= 1'b0;
                end else if (ce) begin
                    r_acc[i]  <= w_sum[i][ACC_W-1:0];
                    r_wrap[i] <= w_sum[i][ACC_W];
                end else begin
                    r_wrap[i] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_multi_phase_accumulator.sv
// Directed + randomized bench for multi_phase_accumulator against an arithmetic reference model.
// Honours PHASE_OFFSET_EN the same way the design does.
module tb_multi_phase_accumulator;
    localparam int unsigned ACC_W  = 23;
    localparam int unsigned OUT_W  = 14;
    localparam int unsigned TUNE_W = 16;
    localparam int unsigned CH     = 4;
    localparam int unsigned CH_W   = 2;
    localparam longint unsigned ACC_MOD = 64'd1 << ACC_W;
    localparam longint unsigned OUT_MOD = 64'd1 << OUT_W;

    logic                clk = 1'b0;
    logic                rst;
    logic                ce;
    logic                phase_sync;
    logic [CH*OUT_W-1:0] phase_out;
    logic [CH-1:0]       wrap;

    multi_phase_accumulator_if #(.CHANNELS(CH), .TUNE_W(TUNE_W)) bus_if ();

    multi_phase_accumulator #(
        .ACC_W   (ACC_W),
        .OUT_W   (OUT_W),
        .TUNE_W  (TUNE_W),
        .CHANNELS(CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ce        (ce),
        .phase_sync(phase_sync),
        .bus       (bus_if),
        .phase_out (phase_out),
        .wrap      (wrap)
    );

    always #5 clk = ~clk;

    longint unsigned m_acc    [CH];
    longint unsigned m_shadow [CH];
    longint unsigned m_active [CH];
    longint unsigned m_off    [CH];
    logic [CH-1:0]   m_wrap;
    bit              m_pending;
    bit              m_rdy;
    int              n_cmp = 0;
    int              n_bad = 0;

    function automatic logic exp_ready();
        return !rst && m_rdy && !m_pending;
    endfunction

    function automatic logic [CH*OUT_W-1:0] exp_po();
        logic [CH*OUT_W-1:0] v;
        v = '0;
        for (int i = 0; i < CH; i++) begin
            v[i*OUT_W +: OUT_W] = OUT_W'(((m_acc[i] >> (ACC_W - OUT_W)) + m_off[i]) % OUT_MOD);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".wr_ready"}, 64'(bus_if.wr_ready), 64'(exp_ready()));
        check({tag, ".wrap"}, 64'(wrap), 64'(m_wrap));
        check({tag, ".phase_out"}, 64'(phase_out), 64'(exp_po()));
    endtask

    task automatic drive(input bit r, input bit c, input bit ps, input bit we,
                         input int unsigned chn, input bit off, input int unsigned data,
                         input bit cm);
        rst            = r;
        ce             = c;
        phase_sync     = ps;
        bus_if.wr_en   = we;
        bus_if.wr_ch   = CH_W'(chn);
        bus_if.wr_off  = off;
        bus_if.wr_data = TUNE_W'(data);
        bus_if.commit  = cm;
    endtask

    // Advance the model by one clock from the currently driven inputs, then step the DUT.
    task automatic tick();
        bit              accept;
        bit              load;
        longint unsigned sum;
        if (rst) begin
            for (int i = 0; i < CH; i++) begin
                m_acc[i] = 0; m_shadow[i] = 0; m_active[i] = 0; m_off[i] = 0;
            end
            m_wrap    = '0;
            m_pending = 0;
            m_rdy     = 0;
        end else begin
            accept = bus_if.wr_en && m_rdy && !m_pending && (int'(bus_if.wr_ch) < CH);
            load   = m_pending && ce;
            for (int i = 0; i < CH; i++) begin
                sum = m_acc[i] + m_active[i];
                if (phase_sync) begin
                    m_acc[i]  = 0;
                    m_wrap[i] = 1'b0;
                end else if (ce) begin
                    m_acc[i]  = sum % ACC_MOD;
                    m_wrap[i] = (sum >= ACC_MOD);
                end else begin
                    m_wrap[i] = 1'b0;
                end
                if (load) m_active[i] = m_shadow[i];
            end
            if (accept) begin
                if (!bus_if.wr_off) m_shadow[bus_if.wr_ch] = bus_if.wr_data;
`ifdef PHASE_OFFSET_EN
                else m_off[bus_if.wr_ch] = bus_if.wr_data % OUT_MOD;
`endif
            end
            if (!m_pending && bus_if.commit) m_pending = 1;
            else if (m_pending && ce) m_pending = 0;
            m_rdy = 1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wcnt;
        int wat;
        logic [OUT_W-1:0] off_exp;
        for (int i = 0; i < CH; i++) begin
            m_acc[i] = 0; m_shadow[i] = 0; m_active[i] = 0; m_off[i] = 0;
        end
        m_wrap = '0; m_pending = 0; m_rdy = 0;

        // Reset and release
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick(); tick();
        check_all("reset");
        check("reset_phase_out", 64'(phase_out), 64'd0);
        check("reset_wr_ready", 64'(bus_if.wr_ready), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("ready_after_rst", 64'(bus_if.wr_ready), 64'd1);

        // ch0 tune 0x0200 written together with commit, then apply and 16 advances
        drive(0, 0, 0, 1, 0, 0, 32'h0200, 1);
        tick();
        check_all("commit0");
        check("pending_ready_lo", 64'(bus_if.wr_ready), 64'd0);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_all("apply0");
        for (int k = 0; k < 16; k++) tick();
        check_all("adv16");
        check("ch0_after_16", 64'(phase_out[0 +: OUT_W]), 64'h0010);

        // Commit held pending by ce=0 for 5 cycles; writes during that window are rejected
        drive(0, 0, 0, 1, 1, 0, 32'hFFFF, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check_all("pend_c0");
        drive(0, 0, 0, 1, 1, 0, 32'h1234, 1);
        for (int k = 0; k < 4; k++) begin
            tick();
            check_all("pend_hold");
            check("pend_ready", 64'(bus_if.wr_ready), 64'd0);
        end
        check("pend_ch0_held", 64'(phase_out[0 +: OUT_W]), 64'h0010);
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        tick();
        check_all("pend_apply");
        check("ready_back", 64'(bus_if.wr_ready), 64'd1);

        // phase_sync beats accumulation with nonzero accumulators
        drive(0, 1, 1, 0, 0, 0, 0, 0);
        tick();
        check_all("sync");
        check("sync_po_zero", 64'(phase_out), 64'd0);
        check("sync_wrap_zero", 64'(wrap), 64'd0);

        // ch1 tune 0xFFFF from zero: single wrap on advance 129
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        wcnt = 0;
        wat  = 0;
        for (int k = 1; k <= 129; k++) begin
            tick();
            check_all("wrap_run");
            if (wrap[1]) begin
                wcnt++;
                wat = k;
            end
        end
        check("wrap1_count", 64'(wcnt), 64'd1);
        check("wrap1_at", 64'(wat), 64'd129);
        check("ch1_after_129", 64'(phase_out[OUT_W +: OUT_W]), 64'(65407 >> (ACC_W - OUT_W)));

        // Offset write to ch2 (tune 0)
        drive(0, 0, 0, 1, 2, 1, 32'h2000, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_all("offset");
`ifdef PHASE_OFFSET_EN
        off_exp = 14'h2000;
`else
        off_exp = 14'h0000;
`endif
        check("ch2_offset", 64'(phase_out[2*OUT_W +: OUT_W]), 64'(off_exp));

        // Randomized traffic
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
                  ($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1,
                  $urandom_range(0, CH - 1), ($urandom_range(0, 3) == 0), $urandom,
                  ($urandom_range(0, 7) == 0));
            tick();
            check_all("random");
        end

        // Reset while a commit is pending
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 1, 3, 0, 32'h4000, 1);
        tick();
        check("pend3_ready", 64'(bus_if.wr_ready), 64'd0);
        drive(1, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check_all("rst_pend");
        check("rst_pend_ready", 64'(bus_if.wr_ready), 64'd0);
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("rst_rel_ready", 64'(bus_if.wr_ready), 64'd1);
        drive(0, 0, 0, 0, 0, 0, 0, 1);
        tick();
        drive(0, 1, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) tick();
        check_all("rst_pend_after");
        check("ch3_shadow_cleared", 64'(phase_out[3*OUT_W +: OUT_W]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
